// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   CPU-bus slave that queues console bytes and feeds them to the uart
//   transmitter one at a time, so software never polls uart busy.
//
//   Optional feature macro: UART_TX_BUFFER_CRLF_EN
//     When defined, a queued LF (8'h0A) goes out on the line as CR then LF.
//
// Ports
//   clk_sys          in   system clock
//   reset_n          in   synchronous, active-low reset
//   bus_valid_i      in   CPU access request
//   bus_addr_i       in   [31:0] byte address
//   bus_wdata_i      in   [31:0] write data (byte in [7:0])
//   bus_wstrb_i      in   [3:0] byte strobes, 0 = read
//   bus_sel_o        out  address decodes to this block (combinational)
//   bus_ready_o      out  one-cycle access-complete pulse
//   bus_rdata_o      out  [31:0] read data, zero unless bus_ready_o
//   uart_wr_strobe_o out  one-cycle byte-load pulse to the uart
//   uart_data_o      out  [7:0] byte presented to the uart
//   uart_busy_i      in   uart is transmitting
//
// Status word: {16'd0, count[7:0], 5'd0, drain_active, full, empty}
// DEPTH must be a power of two (pointers wrap by overflow).

module uart_tx_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] ADDR_DATA   = 32'h0000_1000,
  parameter logic [31:0] ADDR_STATUS = 32'h0000_1008
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        bus_valid_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  input  logic [3:0]  bus_wstrb_i,
  output logic        bus_sel_o,
  output logic        bus_ready_o,
  output logic [31:0] bus_rdata_o,
  output logic        uart_wr_strobe_o,
  output logic [7:0]  uart_data_o,
  input  logic        uart_busy_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [8:0]    count_ext;
  logic          full, empty;
  logic          push, pop;

  logic          sel_data, sel_status;
  logic          respond, ready_set;
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic [31:0]   status_word;
  logic [7:0]    data_q;
  logic          drain_active;

  // Upper write-data bits carry nothing for a byte register.
  logic          unused_wdata_hi;
  assign unused_wdata_hi = ^bus_wdata_i[31:8];

`ifdef UART_TX_BUFFER_CRLF_EN
  logic          lf_pending;
  logic          lf_send;
`endif

  // ---------------------------------------------------------------- decode
  assign sel_data   = (bus_addr_i == ADDR_DATA);
  assign sel_status = (bus_addr_i == ADDR_STATUS);
  assign bus_sel_o  = sel_data | sel_status;

  // Gating on ready_q keeps ready from pulsing on back-to-back cycles.
  assign respond = bus_valid_i & bus_sel_o & ~ready_q;

  // Status accesses and data reads always complete; data writes wait for room.
  assign ready_set = respond & (sel_status | ~(|bus_wstrb_i) | ~full);
  assign push      = respond & sel_data & (|bus_wstrb_i) & ~full;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign count_ext = 9'(count);

  assign drain_active = (state != S_IDLE);
  assign status_word  = {16'd0, count_ext[7:0], 5'd0, drain_active, full, empty};

  assign bus_ready_o      = ready_q;
  assign bus_rdata_o      = rdata_q;
  assign uart_wr_strobe_o = (state == S_STROBE);
  assign uart_data_o      = data_q;

  // ------------------------------------------------------------- drain FSM
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
`ifdef UART_TX_BUFFER_CRLF_EN
    lf_send   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!empty && !uart_busy_i) begin
          pop       = 1'b1;
          state_nxt = S_STROBE;
        end
      end
      S_STROBE: state_nxt = S_GUARD;
      S_GUARD:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (!uart_busy_i) begin
`ifdef UART_TX_BUFFER_CRLF_EN
          // CR already sent: loop straight back for the LF without
          // returning to IDLE, so drain_active stays high across both.
          if (lf_pending) begin
            lf_send   = 1'b1;
            state_nxt = S_STROBE;
          end else begin
            state_nxt = S_IDLE;
          end
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ----------------------------------------------------- FIFO + bus datapath
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr] <= bus_wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef UART_TX_BUFFER_CRLF_EN
      lf_pending <= 1'b0;
`endif
    end else begin
      ready_q <= ready_set;
      rdata_q <= (respond && sel_status) ? status_word : '0;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
`ifdef UART_TX_BUFFER_CRLF_EN
        if (mem[rd_ptr] == 8'h0A) begin
          data_q     <= 8'h0D;
          lf_pending <= 1'b1;
        end else begin
          data_q <= mem[rd_ptr];
        end
`else
        data_q <= mem[rd_ptr];
`endif
      end

`ifdef UART_TX_BUFFER_CRLF_EN
      if (lf_send) begin
        data_q     <= 8'h0A;
        lf_pending <= 1'b0;
      end
`endif

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
module tb_uart_tx_buffer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_sel_o;
  logic        bus_ready_o;
  logic [31:0] bus_rdata_o;
  logic        uart_wr_strobe_o;
  logic [7:0]  uart_data_o;
  logic        uart_busy_i;

  logic        uart_busy_model = 1'b0;
  logic        hold_busy = 1'b0;
  int          busy_len = 10;
  int          busy_cnt = 0;
  logic [7:0]  sent_q[$];
  logic [7:0]  last_byte = 8'h00;
  int          stab_err = 0;

  int checks = 0;
  int errors = 0;

  assign uart_busy_i = uart_busy_model | hold_busy;

  uart_tx_buffer #(
    .DEPTH(16),
    .ADDR_DATA(32'h0000_1000),
    .ADDR_STATUS(32'h0000_1008)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus_valid_i(bus_valid),
    .bus_addr_i(bus_addr),
    .bus_wdata_i(bus_wdata),
    .bus_wstrb_i(bus_wstrb),
    .bus_sel_o(bus_sel_o),
    .bus_ready_o(bus_ready_o),
    .bus_rdata_o(bus_rdata_o),
    .uart_wr_strobe_o(uart_wr_strobe_o),
    .uart_data_o(uart_data_o),
    .uart_busy_i(uart_busy_i)
  );

  always #20 clk_sys = ~clk_sys;

  // uart model: a strobe loads a byte and raises busy for busy_len cycles.
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      uart_busy_model <= 1'b0;
      busy_cnt        <= 0;
    end else if (uart_wr_strobe_o) begin
      sent_q.push_back(uart_data_o);
      last_byte       <= uart_data_o;
      uart_busy_model <= 1'b1;
      busy_cnt        <= busy_len;
    end else if (busy_cnt > 0) begin
      if (uart_data_o !== last_byte) stab_err <= stab_err + 1;
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) uart_busy_model <= 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output int lat, output logic sel);
    @(negedge clk_sys);
    bus_valid = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    bus_wstrb = s;
    #1 sel = bus_sel_o;
    lat = 0;
    do begin
      @(negedge clk_sys);
      lat++;
    end while (!bus_ready_o && lat < 400);
    check("bus_ready", 32'(bus_ready_o), 32'd1);
    rd = bus_rdata_o;
    bus_valid = 1'b0;
    bus_wstrb = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_sel;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        sel;
    logic        saw_ready;
    int          sc;

    // status read, data read, status write (ignored), data read, status read
    vecs[0] = '{32'h0000_1008, 32'h0,         4'h0, 1'b1, 32'h0000_0001};
    vecs[1] = '{32'h0000_1000, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[2] = '{32'h0000_1008, 32'h0000_1234, 4'hF, 1'b1, 32'h0000_0001};
    vecs[3] = '{32'h0000_1000, 32'h0,         4'h0, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_1008, 32'h0,         4'h0, 1'b1, 32'h0000_0001};

    reset_n   = 1'b0;
    bus_valid = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;

    // ---- reset state
    wait_cycles(5);
    check("rst_ready",  32'(bus_ready_o),      32'd0);
    check("rst_rdata",  bus_rdata_o,           32'd0);
    check("rst_strobe", 32'(uart_wr_strobe_o), 32'd0);
    check("rst_data",   32'(uart_data_o),      32'd0);
    reset_n = 1'b1;

    // ---- table: reads/writes that never push
    for (int unsigned i = 0; i < 5; i++) begin
      bus_access(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, lat, sel);
      check("vec_sel",   32'(sel), 32'(vecs[i].exp_sel));
      check("vec_lat",   32'(lat), 32'd1);
      check("vec_rdata", rd,       vecs[i].exp_rdata);
    end
    @(negedge clk_sys);
    check("rdata_idle_zero", bus_rdata_o, 32'd0);
    wait_cycles(10);
    check("no_push_strobes", 32'(sent_q.size()), 32'd0);

    // ---- unmapped address: no select, no ready
    @(negedge clk_sys);
    bus_valid = 1'b1;
    bus_addr  = 32'h0000_1004;
    bus_wstrb = 4'hF;
    bus_wdata = 32'h55;
    #1 check("unmapped_sel", 32'(bus_sel_o), 32'd0);
    saw_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      if (bus_ready_o) saw_ready = 1'b1;
    end
    check("unmapped_ready", 32'(saw_ready), 32'd0);
    bus_valid = 1'b0;
    bus_wstrb = '0;
    wait_cycles(5);
    check("unmapped_no_tx", 32'(sent_q.size()), 32'd0);

    // ---- single byte
    busy_len = 10;
    bus_access(32'h1000, 32'h41, 4'h1, rd, lat, sel);
    check("single_lat", 32'(lat), 32'd1);
    bus_access(32'h1008, 32'h0, 4'h0, rd, lat, sel);
    check("single_status_active", rd, 32'h0000_0005);
    wait_cycles(30);
    check("single_count", 32'(sent_q.size()), 32'd1);
    check("single_byte",  32'(sent_q[0]),     32'h41);
    bus_access(32'h1008, 32'h0, 4'h0, rd, lat, sel);
    check("single_status_done", rd, 32'h0000_0001);

    // ---- 20 bytes into a 16-deep FIFO behind a stalled uart
    sent_q.delete();
    busy_len  = 40;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_access(32'h1000, 32'(8'h41 + i), 4'h1, rd, lat, sel);
      check("fill_lat", 32'(lat), 32'd1);
    end
    bus_access(32'h1008, 32'h0, 4'h0, rd, lat, sel);
    check("full_status", rd, 32'h0000_1002);
    fork
      bus_access(32'h1000, 32'h51, 4'h1, rd, lat, sel);
      begin
        wait_cycles(20);
        hold_busy = 1'b0;
      end
    join
    check("stall_lat", 32'(lat), 32'd21);
    for (int i = 17; i < 20; i++) begin
      bus_access(32'h1000, 32'(8'h41 + i), 4'h1, rd, lat, sel);
    end
    for (int i = 0; i < 3; i++) begin
      bus_access(32'h1008, 32'h0, 4'h0, rd, lat, sel);
      check("count_le_16", 32'(rd[15:8] <= 8'd16), 32'd1);
      wait_cycles(50);
    end
    sc = 0;
    while (sent_q.size() < 20 && sc < 2000) begin
      @(negedge clk_sys);
      sc++;
    end
    wait_cycles(50);
    check("burst_total", 32'(sent_q.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      check("burst_order", 32'(sent_q[i]), 32'(8'h41 + i));
    end
    bus_access(32'h1008, 32'h0, 4'h0, rd, lat, sel);
    check("burst_status_done", rd, 32'h0000_0001);

    // ---- LF handling
    sent_q.delete();
    busy_len = 10;
    bus_access(32'h1000, 32'h0A, 4'h1, rd, lat, sel);
    wait_cycles(60);
`ifdef UART_TX_BUFFER_CRLF_EN
    check("lf_count", 32'(sent_q.size()), 32'd2);
    check("lf_cr",    32'(sent_q[0]),     32'h0D);
    check("lf_lf",    32'(sent_q[1]),     32'h0A);
`else
    check("lf_count", 32'(sent_q.size()), 32'd1);
    check("lf_lf",    32'(sent_q[0]),     32'h0A);
`endif

    // ---- reset while waiting on the uart with bytes queued
    sent_q.delete();
    busy_len = 30;
    for (int i = 0; i < 6; i++) begin
      bus_access(32'h1000, 32'(8'h30 + i), 4'h1, rd, lat, sel);
    end
    sc = 0;
    while (!uart_busy_model && sc < 50) begin
      @(negedge clk_sys);
      sc++;
    end
    wait_cycles(3);
    check("pre_reset_sent", 32'(sent_q.size()), 32'd1);
    reset_n = 1'b0;
    wait_cycles(3);
    reset_n = 1'b1;
    check("mid_rst_strobe", 32'(uart_wr_strobe_o), 32'd0);
    check("mid_rst_data",   32'(uart_data_o),      32'd0);
    sc = sent_q.size();
    wait_cycles(100);
    check("post_reset_no_tx", 32'(sent_q.size()), 32'(sc));
    bus_access(32'h1008, 32'h0, 4'h0, rd, lat, sel);
    check("post_reset_status", rd, 32'h0000_0001);

    check("data_stable_while_busy", 32'(stab_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
